// File: rtl/f4_pkg.sv
// Shared encodings for the F-4 run controller: FSM states, run status codes, counter sizing.
// Combinational only; no latency, no flow control.
package f4_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RESET = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        ST_NONE    = 2'b00,
        ST_HALT    = 2'b01,
        ST_TIMEOUT = 2'b10,
        ST_RSVD    = 2'b11
    } status_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/f4_stall_det.sv
// Halt detector: tracks the last fetched PC and counts consecutive repeated fetches.
// halt is combinational from registered state plus this cycle's fetch; no backpressure.
module f4_stall_det
    import f4_pkg::*;
#(
    parameter int AW           = 16,
    parameter int STALL_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic [AW-1:0] pc,
    input  logic          pc_valid,
    output logic          halt
);

    localparam int SCW = cnt_w(STALL_CYCLES + 1);

    logic [AW-1:0]  last_pc_q, last_pc_d;
    logic [SCW-1:0] stall_cnt_q, stall_cnt_d;
    logic           seen_q, seen_d;
    logic           fetch;
    logic           repeat_hit;

    assign fetch      = en && pc_valid;
    assign repeat_hit = fetch && seen_q && (pc == last_pc_q);
    // The fetch that makes the count reach STALL_CYCLES raises halt in the same cycle.
    assign halt       = repeat_hit && (stall_cnt_q >= SCW'(STALL_CYCLES - 1));

    always_comb begin
        last_pc_d   = last_pc_q;
        stall_cnt_d = stall_cnt_q;
        seen_d      = seen_q;
        if (clr) begin
            last_pc_d   = '0;
            stall_cnt_d = '0;
            seen_d      = 1'b0;
        end else if (fetch) begin
            if (!seen_q) begin
                seen_d      = 1'b1;
                last_pc_d   = pc;
                stall_cnt_d = '0;
            end else if (repeat_hit) begin
                if (stall_cnt_q != SCW'(STALL_CYCLES)) begin
                    stall_cnt_d = stall_cnt_q + SCW'(1);
                end
            end else begin
                last_pc_d   = pc;
                stall_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_pc_q   <= '0;
            stall_cnt_q <= '0;
            seen_q      <= 1'b0;
        end else begin
            last_pc_q   <= last_pc_d;
            stall_cnt_q <= stall_cnt_d;
            seen_q      <= seen_d;
        end
    end

endmodule

// File: rtl/f4_run_ctrl.sv
// Run controller for the F-4 core: holds core reset for RST_CYCLES, runs, ends on halt or cycle budget.
// RUN begins RST_CYCLES edges after start is sampled; all outputs registered; start ignored outside IDLE/DONE.
module f4_run_ctrl
    import f4_pkg::*;
#(
    parameter int AW           = 16,
    parameter int CW           = 32,
    parameter int RST_CYCLES   = 4,
    parameter int MAX_CYCLES   = 100,
    parameter int STALL_CYCLES = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] pc,
    input  logic          pc_valid,
    output logic          core_rstn,
    output logic          core_en,
    output logic          done,
    output logic [1:0]    status,
    output logic [CW-1:0] cycles
);

    localparam int RCW = cnt_w(RST_CYCLES);

    state_e         state_q, state_d;
    status_e        status_q, status_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [CW-1:0]  cycles_q, cycles_d;
    logic [CW-1:0]  cycles_inc;
    logic           core_rstn_q, core_rstn_d;
    logic           core_en_q, core_en_d;
    logic           done_q, done_d;
    logic           stall_clr;
    logic           stall_en;
    logic           halt;

    assign stall_clr  = (state_q == S_RESET);
    assign stall_en   = (state_q == S_RUN);
    assign cycles_inc = cycles_q + CW'(1);

    f4_stall_det #(
        .AW           (AW),
        .STALL_CYCLES (STALL_CYCLES)
    ) u_stall_det (
        .clk      (clk),
        .rst      (rst),
        .clr      (stall_clr),
        .en       (stall_en),
        .pc       (pc),
        .pc_valid (pc_valid),
        .halt     (halt)
    );

    always_comb begin
        state_d     = state_q;
        status_d    = status_q;
        rst_cnt_d   = rst_cnt_q;
        cycles_d    = cycles_q;
        core_rstn_d = core_rstn_q;
        core_en_d   = core_en_q;
        done_d      = done_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d     = S_RESET;
                    rst_cnt_d   = '0;
                    cycles_d    = '0;
                    status_d    = ST_NONE;
                    done_d      = 1'b0;
                    core_rstn_d = 1'b0;
                    core_en_d   = 1'b0;
                end
            end
            S_RESET: begin
                if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
                    state_d     = S_RUN;
                    core_rstn_d = 1'b1;
                    core_en_d   = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + RCW'(1);
                end
            end
            S_RUN: begin
                cycles_d = cycles_inc;
                // Halt takes priority when both end conditions land on the same edge.
                if (halt) begin
                    state_d   = S_DONE;
                    status_d  = ST_HALT;
                    done_d    = 1'b1;
                    core_en_d = 1'b0;
                end else if (cycles_inc == CW'(MAX_CYCLES)) begin
                    state_d   = S_DONE;
                    status_d  = ST_TIMEOUT;
                    done_d    = 1'b1;
                    core_en_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            status_q    <= ST_NONE;
            rst_cnt_q   <= '0;
            cycles_q    <= '0;
            core_rstn_q <= 1'b0;
            core_en_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            status_q    <= status_d;
            rst_cnt_q   <= rst_cnt_d;
            cycles_q    <= cycles_d;
            core_rstn_q <= core_rstn_d;
            core_en_q   <= core_en_d;
            done_q      <= done_d;
        end
    end

    assign core_rstn = core_rstn_q;
    assign core_en   = core_en_q;
    assign done      = done_q;
    assign status    = status_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_f4_run_ctrl.sv
// Bench for f4_run_ctrl: directed launch/halt/timeout/tie/abort runs, then random traffic against a run-level model.
module tb_f4_run_ctrl;

    localparam int AW     = 16;
    localparam int CW     = 32;
    localparam int RSTC   = 4;
    localparam int MAXC   = 100;
    localparam int STALLC = 8;

    localparam int M_IDLE  = 0;
    localparam int M_RESET = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          core_rstn;
    logic          core_en;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycles;

    f4_run_ctrl #(
        .AW           (AW),
        .CW           (CW),
        .RST_CYCLES   (RSTC),
        .MAX_CYCLES   (MAXC),
        .STALL_CYCLES (STALLC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .core_rstn (core_rstn),
        .core_en   (core_en),
        .done      (done),
        .status    (status),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Run-level model: phase, cycles spent in reset, run cycles, result, valid fetches of this run.
    int m_mode   = M_IDLE;
    int m_rcnt   = 0;
    int m_cycles = 0;
    int m_status = 0;
    int pcq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Halted when the last STALLC+1 valid fetches of the run are all the same address.
    function automatic bit stalled();
        int n;
        n = pcq.size();
        if (n < STALLC + 1) return 1'b0;
        for (int i = 1; i <= STALLC; i++) begin
            if (pcq[n-1-i] != pcq[n-1]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_mode   = M_IDLE;
            m_cycles = 0;
            m_status = 0;
            pcq.delete();
        end else begin
            case (m_mode)
                M_IDLE, M_DONE: begin
                    if (start) begin
                        m_mode   = M_RESET;
                        m_rcnt   = 0;
                        m_cycles = 0;
                        m_status = 0;
                        pcq.delete();
                    end
                end
                M_RESET: begin
                    m_rcnt++;
                    if (m_rcnt == RSTC) m_mode = M_RUN;
                end
                default: begin
                    m_cycles++;
                    if (pc_valid) pcq.push_back(int'(pc));
                    if (pc_valid && stalled()) begin
                        m_mode   = M_DONE;
                        m_status = 1;
                    end else if (m_cycles == MAXC) begin
                        m_mode   = M_DONE;
                        m_status = 2;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("core_rstn", core_rstn, (m_mode == M_RUN || m_mode == M_DONE));
        chk("core_en", core_en, (m_mode == M_RUN));
        chk("done", done, (m_mode == M_DONE));
        chk("status", status, m_status);
        chk("cycles", cycles, m_cycles);
    endtask

    task automatic launch();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RSTC) step();
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pc       = '0;
        pc_valid = 1'b0;

        // Power-up: reset values, core held in reset while idle.
        step();
        step();
        chk("pwr_status", status, 0);
        chk("pwr_cycles", cycles, 0);
        rst = 1'b0;
        repeat (6) step();
        chk("idle_rstn", core_rstn, 0);
        chk("idle_done", done, 0);

        // Launch timing, then halt on PC sequence 0,1,2,3,3,3,...
        pc       = '0;
        pc_valid = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("launch_rstn_first", core_rstn, 0);
        repeat (RSTC - 1) begin
            step();
            chk("launch_rstn_low", core_rstn, 0);
        end
        step();
        chk("run_rstn", core_rstn, 1);
        chk("run_en", core_en, 1);
        chk("run_cycles0", cycles, 0);
        for (int k = 1; k <= 12; k++) begin
            pc = AW'((k < 4) ? k - 1 : 3);
            step();
            if (k < 12) chk("halt_running", cycles, k);
        end
        chk("halt_done", done, 1);
        chk("halt_status", status, 1);
        chk("halt_cycles", cycles, 12);
        chk("halt_en", core_en, 0);
        repeat (5) begin
            pc_valid = 1'($urandom);
            pc       = AW'($urandom);
            step();
        end
        chk("halt_hold_cycles", cycles, 12);

        // Restart from DONE, then timeout with an always-moving PC.
        pc_valid = 1'b1;
        start    = 1'b1;
        step();
        start = 1'b0;
        chk("restart_done_low", done, 0);
        chk("restart_cycles_clr", cycles, 0);
        chk("restart_status_clr", status, 0);
        repeat (RSTC) step();
        for (int k = 1; k <= MAXC; k++) begin
            pc = AW'(k);
            step();
        end
        chk("to_done", done, 1);
        chk("to_status", status, 2);
        chk("to_cycles", cycles, MAXC);
        chk("to_en", core_en, 0);
        repeat (50) begin
            pc       = AW'($urandom);
            pc_valid = 1'($urandom);
            step();
            chk("to_hold_done", done, 1);
            chk("to_hold_status", status, 2);
            chk("to_hold_cycles", cycles, MAXC);
        end

        // Tie: eighth repeat lands on the budget cycle, halt reported.
        pc_valid = 1'b1;
        launch();
        for (int k = 1; k <= MAXC; k++) begin
            pc = AW'((k <= MAXC - STALLC) ? k : MAXC - STALLC);
            step();
        end
        chk("tie_done", done, 1);
        chk("tie_status", status, 1);
        chk("tie_cycles", cycles, MAXC);

        // Abort mid-run with rst, then a full relaunch.
        launch();
        for (int k = 1; k <= 30; k++) begin
            pc = AW'(1000 + k);
            step();
        end
        chk("abort_pre_cycles", cycles, 30);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_rstn", core_rstn, 0);
        chk("abort_en", core_en, 0);
        chk("abort_cycles", cycles, 0);
        chk("abort_done", done, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (RSTC - 1) begin
            step();
            chk("relaunch_rstn_low", core_rstn, 0);
        end
        step();
        chk("relaunch_rstn_high", core_rstn, 1);

        // Random traffic: sticky PCs so halts and timeouts both occur, occasional starts and resets.
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 249) == 0);
            start    = ($urandom_range(0, 5) == 0);
            pc_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) pc = AW'($urandom_range(0, 7));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
